// File: rtl/mem_pkg.sv
// Shared load/store definitions: op codes, exception codes, FSM states.
// Also used by the write-back stage through mem_load_extract.
package mem_pkg;

   typedef enum logic [2:0] {
      MEM_W  = 3'd0,
      MEM_H  = 3'd1,
      MEM_HU = 3'd2,
      MEM_B  = 3'd3,
      MEM_BU = 3'd4
   } mem_op_e;

   typedef enum logic [1:0] {
      EXC_NONE  = 2'b00,
      EXC_ADEL  = 2'b01,
      EXC_ADES  = 2'b10,
      EXC_BADOP = 2'b11
   } mem_exc_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_RESP    = 2'd2
   } mau_state_e;

   function automatic logic op_legal(input logic [2:0] op);
      return op <= 3'd4;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus data-RAM port of the load/store unit.
// slave = the unit, master = execute stage / RAM side.
interface mem_access_unit_if #(
   parameter int ADDR_W = 12
);

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_op;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic [31:0]       req_pc;
   logic              resp_valid;
   logic              resp_ready;
   logic [31:0]       resp_rdata;
   logic [1:0]        resp_exc;
   logic [31:0]       resp_pc;
   logic              ram_en;
   logic [3:0]        ram_we;
   logic [ADDR_W-3:0] ram_addr;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;

   modport slave (
      input  req_valid, req_we, req_op, req_addr, req_wdata, req_pc,
      input  resp_ready, ram_rdata,
      output req_ready, resp_valid, resp_rdata, resp_exc, resp_pc,
      output ram_en, ram_we, ram_addr, ram_wdata
   );

   modport master (
      output req_valid, req_we, req_op, req_addr, req_wdata, req_pc,
      output resp_ready, ram_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_exc, resp_pc,
      input  ram_en, ram_we, ram_addr, ram_wdata
   );

endinterface

// File: rtl/mem_load_extract.sv
// Picks the byte/half/word out of a RAM word and sign/zero-extends it.
// Purely combinational so write-back can reuse it.
module mem_load_extract
   import mem_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [2:0]  op_i,
   input  logic [1:0]  a_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_w;
   logic [15:0] half_w;

   // lane select then extension by op
   always_comb begin
      unique case (a_i)
         2'd0:    byte_w = word_i[7:0];
         2'd1:    byte_w = word_i[15:8];
         2'd2:    byte_w = word_i[23:16];
         default: byte_w = word_i[31:24];
      endcase
      half_w = a_i[1] ? word_i[31:16] : word_i[15:0];
      unique case (op_i)
         MEM_B:   data_o = {{24{byte_w[7]}}, byte_w};
         MEM_BU:  data_o = {24'd0, byte_w};
         MEM_H:   data_o = {{16{half_w[15]}}, half_w};
         MEM_HU:  data_o = {16'd0, half_w};
         default: data_o = word_i;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end: alignment/range checks, lane-aligned stores,
// one-cycle-latency loads with extraction, held response until taken.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int ADDR_W = 12
) (
   input logic              clk,
   input logic              reset,
   mem_access_unit_if.slave bus
);

   mau_state_e  state_q, state_d;
   logic [2:0]  op_q;
   logic [1:0]  a_q;
   logic [31:0] pc_q;
   mem_exc_e    exc_q;
   logic [31:0] rdata_q;

   logic        accept;
   logic        addr_oob;
   logic        misal;
   mem_exc_e    req_exc;
   logic [3:0]  lanes;
   logic [31:0] ld_data;

   assign accept = (state_q == ST_IDLE) && bus.req_valid && !reset;

   // request classification: bad op beats address faults beats HU/BU store
   always_comb begin
      addr_oob = (bus.req_addr >> ADDR_W) != 32'd0;
      unique case (bus.req_op)
         MEM_W:         misal = bus.req_addr[1:0] != 2'b00;
         MEM_H, MEM_HU: misal = bus.req_addr[0];
         default:       misal = 1'b0;
      endcase
      req_exc = EXC_NONE;
      if (!op_legal(bus.req_op)) begin
         req_exc = EXC_BADOP;
      end else if (addr_oob || misal) begin
         req_exc = bus.req_we ? EXC_ADES : EXC_ADEL;
      end else if (bus.req_we &&
                   (bus.req_op == MEM_HU || bus.req_op == MEM_BU)) begin
         req_exc = EXC_BADOP;
      end
   end

   // store lane enables and replicated write data
   always_comb begin
      unique case (bus.req_op)
         MEM_B: begin
            lanes         = 4'b0001 << bus.req_addr[1:0];
            bus.ram_wdata = {4{bus.req_wdata[7:0]}};
         end
         MEM_H: begin
            lanes         = bus.req_addr[1] ? 4'b1100 : 4'b0011;
            bus.ram_wdata = {2{bus.req_wdata[15:0]}};
         end
         default: begin
            lanes         = 4'b1111;
            bus.ram_wdata = bus.req_wdata;
         end
      endcase
   end

   // next state and RAM strobe; RAM is only touched in the accept cycle
   always_comb begin
      state_d    = state_q;
      bus.ram_en = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (req_exc != EXC_NONE) begin
                  state_d = ST_RESP;
               end else begin
                  bus.ram_en = 1'b1;
                  state_d    = bus.req_we ? ST_RESP : ST_RD_WAIT;
               end
            end
         end
         ST_RD_WAIT: state_d = ST_RESP;
         ST_RESP:    if (bus.resp_ready) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   assign bus.ram_we     = (bus.ram_en && bus.req_we) ? lanes : 4'b0000;
   assign bus.ram_addr   = bus.req_addr[ADDR_W-1:2];
   assign bus.req_ready  = (state_q == ST_IDLE);
   assign bus.resp_valid = (state_q == ST_RESP) && !reset;
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_exc   = exc_q;
   assign bus.resp_pc    = pc_q;

   mem_load_extract u_extract (
      .word_i (bus.ram_rdata),
      .op_i   (op_q),
      .a_i    (a_q),
      .data_o (ld_data)
   );

   // state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // request context captured on accept, load data captured in RD_WAIT
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q    <= 3'd0;
         a_q     <= 2'd0;
         pc_q    <= 32'd0;
         exc_q   <= EXC_NONE;
         rdata_q <= 32'd0;
      end else if (accept) begin
         op_q    <= bus.req_op;
         a_q     <= bus.req_addr[1:0];
         pc_q    <= bus.req_pc;
         exc_q   <= req_exc;
         rdata_q <= 32'd0;
      end else if (state_q == ST_RD_WAIT) begin
         rdata_q <= ld_data;
      end
   end

endmodule
